servant_wb_loader: RTL and testbench

Wishbone initiator that boots the servant SoC from a byte stream, for example from a UART receiver. It packs incoming bytes little-endian into 32-bit words and writes them sequentially from word address 0 into the servant RAM over Wishbone classic cycles. While loading it holds the CPU in reset; it releases the CPU on flush or when memory is full.

---
 rtl/servant_loader_pkg.sv | 26 ++
 rtl/servant_wb_loader.sv | 118 +++++++++++
 tb/tb_servant_wb_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/servant_loader_pkg.sv
// Shared types and constants for the servant Wishbone boot loader.
package servant_loader_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_B01  = 4'b0011;
  localparam logic [3:0] SEL_B012 = 4'b0111;
  localparam logic [3:0] SEL_ALL  = 4'b1111;

  // Lane mask for a word holding k packed bytes (k = 1..4).
  function automatic logic [3:0] lane_mask(input logic [2:0] k);
    case (k)
      3'd1:    lane_mask = SEL_B0;
      3'd2:    lane_mask = SEL_B01;
      3'd3:    lane_mask = SEL_B012;
      3'd4:    lane_mask = SEL_ALL;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/servant_wb_loader.sv
// Byte-stream boot loader: packs bytes little-endian into words and writes them
// from word 0 upward over Wishbone classic, holding the CPU in reset until done.
module servant_wb_loader
  import servant_loader_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic [7:0]    i_dat,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic          i_flush,
  output logic [aw-1:2] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack,
  output logic          o_done,
  output logic          o_cpu_rst
);

  state_e        state_q;
  logic          run_q;
  logic [2:0]    k_q, k_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q;
  logic [aw-3:0] adr_q;
  logic          cyc_q, we_q, done_q, pend_q;
  logic          acc, flush_ok;

  // run_q keeps o_rdy low until the first edge after reset release.
  assign o_rdy    = run_q && (state_q == COLLECT);
  assign acc      = o_rdy && i_vld;
  assign flush_ok = o_rdy && i_flush;

  always_comb begin
    dat_d = dat_q;
    k_d   = k_q;
    if (acc) begin
      dat_d[{k_q[1:0], 3'b000} +: 8] = i_dat;
      k_d = k_q + 3'd1;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= COLLECT;
      run_q   <= 1'b0;
      k_q     <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      adr_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        COLLECT: begin
          dat_q <= dat_d;
          k_q   <= k_d;
          // A flush arriving with the 4th byte still lets the full word go out first.
          if (k_d == 3'd4) begin
            sel_q   <= SEL_ALL;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            pend_q  <= flush_ok;
            state_q <= WRITE;
          end else if (flush_ok) begin
            if (k_d == 3'd0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              sel_q   <= lane_mask(k_d);
              cyc_q   <= 1'b1;
              we_q    <= 1'b1;
              pend_q  <= 1'b1;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (i_wb_ack) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            k_q   <= '0;
            dat_q <= '0;
            sel_q <= '0;
            if (pend_q || (adr_q == '1)) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              adr_q   <= adr_q + 1'b1;
              state_q <= COLLECT;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_sel  = sel_q;
  assign o_wb_we   = we_q;
  assign o_wb_cyc  = cyc_q;
  assign o_done    = done_q;
  assign o_cpu_rst = ~done_q;

endmodule

// File: tb/tb_servant_wb_loader.sv
// Scoreboard bench for servant_wb_loader against a byte-lane RAM model with programmable ack latency.
module tb_servant_wb_loader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk, rst_n;
  logic [7:0]    i_dat;
  logic          i_vld, i_flush, o_rdy;
  logic [AW-1:2] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we, o_wb_cyc, ack;
  logic          o_done, o_cpu_rst;

  servant_wb_loader #(.depth(DEPTH), .aw(AW)) dut (
    .i_wb_clk  (clk),
    .i_wb_rst_n(rst_n),
    .i_dat     (i_dat),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .i_flush   (i_flush),
    .o_wb_adr  (o_wb_adr),
    .o_wb_dat  (o_wb_dat),
    .o_wb_sel  (o_wb_sel),
    .o_wb_we   (o_wb_we),
    .o_wb_cyc  (o_wb_cyc),
    .i_wb_ack  (ack),
    .o_done    (o_done),
    .o_cpu_rst (o_cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  wr_t  exp_q[$];
  int   vecs = 0;
  int   errs = 0;
  int   ack_delay = 0;
  int   cnt;
  logic [31:0] mem [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.adr = a; w.dat = d; w.sel = s;
    exp_q.push_back(w);
  endtask

  // RAM slave: ack after ack_delay idle cycles, one-cycle ack pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
      cnt <= 0;
    end else if (o_wb_cyc && !ack) begin
      if (cnt >= ack_delay) begin
        ack <= 1'b1;
        cnt <= 0;
      end else cnt <= cnt + 1;
    end else begin
      ack <= 1'b0;
      cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && o_wb_cyc && ack)
      for (int i = 0; i < 4; i++)
        if (o_wb_sel[i]) mem[o_wb_adr][8*i +: 8] <= o_wb_dat[8*i +: 8];
  end

  // Monitor: compares each acknowledged write with the scoreboard head.
  initial begin
    int          clen;
    logic [1:0]  c_adr;
    logic [31:0] c_dat;
    logic [3:0]  c_sel;
    wr_t         w;
    clen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !o_wb_cyc) clen = 0;
      else begin
        if (clen == 0) begin
          c_adr = o_wb_adr; c_dat = o_wb_dat; c_sel = o_wb_sel;
          chk("we_with_cyc", {31'd0, o_wb_we}, 32'd1);
        end else begin
          chk("adr_stable", {30'd0, o_wb_adr}, {30'd0, c_adr});
          chk("dat_stable", o_wb_dat, c_dat);
          chk("sel_stable", {28'd0, o_wb_sel}, {28'd0, c_sel});
        end
        clen++;
        if (ack) begin
          if (exp_q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_write: adr %h dat %h sel %h, want none", o_wb_adr, o_wb_dat, o_wb_sel);
          end else begin
            w = exp_q.pop_front();
            chk("wr_adr", {30'd0, o_wb_adr}, {30'd0, w.adr});
            chk("wr_dat", o_wb_dat, w.dat);
            chk("wr_sel", {28'd0, o_wb_sel}, {28'd0, w.sel});
            chk("cyc_len", clen, ack_delay + 2);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; i_vld = 1'b0; i_flush = 1'b0; i_dat = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rdy", {31'd0, o_rdy}, 32'd0);
    chk("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("rst_we", {31'd0, o_wb_we}, 32'd0);
    chk("rst_sel", {28'd0, o_wb_sel}, 32'd0);
    chk("rst_dat", o_wb_dat, 32'd0);
    chk("rst_adr", {30'd0, o_wb_adr}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_rdy(input string nm);
    int t = 0;
    @(negedge clk);
    while (!o_rdy && t < 200) begin @(negedge clk); t++; end
    if (!o_rdy) begin
      vecs++; errs++;
      $display("FAIL %s_timeout: o_rdy still 0, want 1", nm);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    wait_rdy("send");
    i_dat = b; i_vld = 1'b1; i_flush = fl;
    @(posedge clk); #1;
    i_vld = 1'b0; i_flush = 1'b0;
  endtask

  task automatic flush_only();
    wait_rdy("flush");
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!o_done && t < 200) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("done", {31'd0, o_done}, 32'd1);
    chk("cpu_rst_released", {31'd0, o_cpu_rst}, 32'd0);
    chk("cyc_idle", {31'd0, o_wb_cyc}, 32'd0);
    chk("writes_outstanding", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] full_w [4];
    full_w[0] = 32'h13121110; full_w[1] = 32'h17161514;
    full_w[2] = 32'h1B1A1918; full_w[3] = 32'h1F1E1D1C;

    // Single word then an empty flush.
    do_reset();
    push(2'd0, 32'h00000413, 4'hF);
    send(8'h13, 1'b0); send(8'h04, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    flush_only();
    wait_done();

    // Partial trailing word, flush held with the 9th byte.
    do_reset();
    push(2'd0, 32'h04030201, 4'hF);
    push(2'd1, 32'h08070605, 4'hF);
    push(2'd2, 32'h00000009, 4'h1);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    send(8'h09, 1'b1);
    wait_done();
    chk("mem0", mem[0], 32'h04030201);
    chk("mem1", mem[1], 32'h08070605);
    chk("mem2_b0", {24'd0, mem[2][7:0]}, 32'h09);

    // Slow ack, then reset in the middle of a bus cycle.
    do_reset();
    ack_delay = 5;
    push(2'd0, 32'hDDCCBBAA, 4'hF);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    wait_rdy("slow_ack");
    chk("slow_writes_outstanding", exp_q.size(), 32'd0);
    ack_delay = 50;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    repeat (3) @(negedge clk);
    chk("cyc_before_rst", {31'd0, o_wb_cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("cyc_async_drop", {31'd0, o_wb_cyc}, 32'd0);
    chk("rdy_in_rst", {31'd0, o_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    @(posedge clk); #1;
    chk("post_rst_rdy", {31'd0, o_rdy}, 32'd1);
    chk("post_rst_adr", {30'd0, o_wb_adr}, 32'd0);
    chk("post_rst_dat", o_wb_dat, 32'd0);
    chk("post_rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);

    // Full memory: 16 bytes fill 4 words, the rest must be refused.
    do_reset();
    for (int i = 0; i < 4; i++) push(2'(i), full_w[i], 4'hF);
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0);
    wait_done();
    for (int i = 16; i < 20; i++) begin
      i_dat = 8'h10 + 8'(i); i_vld = 1'b1;
      @(negedge clk);
      chk("full_refuse_rdy", {31'd0, o_rdy}, 32'd0);
    end
    i_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_no_cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("full_adr_hold", {30'd0, o_wb_adr}, 32'd3);
    for (int i = 0; i < 4; i++) chk("readback", mem[i], full_w[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
